rob_phase_tracker: RTL and testbench
====================================

# rob_phase_tracker

Parametrised commit-stream phase tracker for the ROB-sync simulation harness. Watches up to COMMIT_WIDTH retiring instructions per cycle for marker instructions (`slti x0, x0, code`). It keeps per-phase active state, duration and peak-taint bookkeeping, and pushes one event record per marker into an internal FIFO drained through a valid/ready port. One instance sits on the DUT core and one on the variant core; a logging consumer drains the FIFO in place of direct file writes from commit-time functions.

## Interface
- COMMIT_WIDTH, 2, number of commit lanes (1..8)
- NUM_PHASES, 7, number of phases; phase p uses code 2p for start and 2p+1 for end
- CNT_W, 32, width of cycle counter, timestamps and durations
- TAINT_W, 32, width of taint_sum and peak fields
- FIFO_DEPTH, 8, event FIFO entries; power of two, at least COMMIT_WIDTH
- clock  in  1  sole clock
- reset  in  1  synchronous, active-high
- commit_valid  in  COMMIT_WIDTH  lane i retires an instruction this cycle
- commit_inst  in  32*COMMIT_WIDTH  lane i instruction at bits [32i+31:32i]
- taint_sum  in  TAINT_W  current core taint sum, sampled every cycle
- evt_valid  out  1  FIFO head valid
- evt_ready  in  1  consumer accepts head
- evt_phase  out  $clog2(NUM_PHASES)  phase id
- evt_is_end  out  1  0 = start, 1 = end
- evt_lane  out  $clog2(COMMIT_WIDTH) (min 1)  lane that committed the marker
- evt_time  out  CNT_W  cycle-counter value in the commit cycle
- evt_duration  out  CNT_W  end: cycles since matching start; start: 0
- evt_peak  out  TAINT_W  end: max taint_sum over the phase; start: taint_sum at start
- phase_active  out  NUM_PHASES  per-phase active flags
- err_dup_start  out  1  sticky: start seen on an already-active phase
- err_orphan_end  out  1  sticky: end seen on an inactive phase
- drop_cnt  out  16  saturating count of records lost to a full FIFO

## Operation
- Marker decode: commit_valid[i], inst[19:0]==20'h02013, and code=inst[31:20] < 2*NUM_PHASES. Phase = code>>1, is_end = code[0]. Any other instruction is ignored.
- cycle_cnt: 0 in the first cycle after reset deasserts, then +1 per cycle, wrapping modulo 2^CNT_W.
- Lanes are processed in ascending index within a cycle. A later lane sees phase state already updated by earlier lanes.
- Start on an inactive phase: set active, start_time[p] = cycle_cnt, peak[p] = taint_sum, push a record.
- Start on an active phase: set err_dup_start, restart start_time and peak, push a record.
- End on an active phase: clear active, push a record with duration = cycle_cnt - start_time[p] (modular) and peak = max(peak[p], taint_sum).
- End on an inactive phase: set err_orphan_end, push a record with duration 0 and peak = taint_sum.
- Peak update: every cycle, for each active phase, peak[p] = max(peak[p], taint_sum). Comparison is unsigned.
- FIFO: up to COMMIT_WIDTH pushes per cycle, in lane order. Free slots are counted after this cycle's pop. Pushes beyond the free slots are dropped, and drop_cnt adds the number dropped, saturating at 16'hFFFF. Phase state still updates for dropped markers.
- Pop occurs when evt_valid and evt_ready are both high. Push and pop in the same cycle are legal at any occupancy.

## Timing
- Reset values: evt_valid 0; all evt_* fields 0; phase_active 0; err_* 0; drop_cnt 0; cycle_cnt 0; FIFO empty; start_time and peak 0.
- A marker in cycle t updates phase_active at t+1 and appears at the FIFO head no earlier than t+1 (registered FIFO, no bypass).
- evt_* fields are stable while evt_valid=1 and evt_ready=0.
- Start and end of the same phase in one cycle (lower lane first): duration 0, record order start then end, phase_active unchanged at t+1. End then start gives a fresh active phase.
- Reset asserted mid-operation clears all state at the next edge. Queued records are discarded without counting as drops.

## Test plan
- Lane 0 commits 0x00202013 at cycle 10, then 0x00302013 at cycle 25, with evt_ready=1 and taint_sum=5 except 9 at cycle 18 -> records (phase1, start, time 10, peak 5) then (phase1, end, time 25, duration 15, peak 9); phase_active[1] high cycles 11..25.
- COMMIT_WIDTH=2: lane0=0x00002013 and lane1=0x00102013 in one cycle -> start then end of phase0, duration 0, lanes 0/1, phase_active[0] stays 0.
- 0x00502013 with phase2 inactive -> err_orphan_end=1, record (phase2, end, duration 0). A second 0x00002013 while phase0 is active -> err_dup_start=1 and start_time restarted.
- evt_ready=0, 10 markers across cycles, FIFO_DEPTH=8 -> 8 records held, drop_cnt=2. Then evt_ready=1 -> 8 records drain in commit order.
- 0x01002013 (code 16 ≥ 14) and 0x00002093 (rd≠0) -> no record, no state change.
- Reset pulse with 3 records queued and phase 3 active -> next cycle evt_valid=0, phase_active=0, drop_cnt=0, cycle_cnt restarts at 0.

Source files
------------

// File: rtl/rob_phase_tracker.sv
// rob_phase_tracker
// Watches the retiring instruction stream for `slti x0, x0, code` markers,
// keeps per-phase active/start-time/peak-taint bookkeeping and queues one
// event record per marker into a small FIFO drained over valid/ready.
module rob_phase_tracker #(
  parameter int COMMIT_WIDTH = 2,
  parameter int NUM_PHASES   = 7,
  parameter int CNT_W        = 32,
  parameter int TAINT_W      = 32,
  parameter int FIFO_DEPTH   = 8,
  localparam int PH_W        = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1,
  localparam int LANE_W      = (COMMIT_WIDTH > 1) ? $clog2(COMMIT_WIDTH) : 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [COMMIT_WIDTH-1:0]   commit_valid,
  input  logic [32*COMMIT_WIDTH-1:0] commit_inst,
  input  logic [TAINT_W-1:0]        taint_sum,
  output logic                      evt_valid,
  input  logic                      evt_ready,
  output logic [PH_W-1:0]           evt_phase,
  output logic                      evt_is_end,
  output logic [LANE_W-1:0]         evt_lane,
  output logic [CNT_W-1:0]          evt_time,
  output logic [CNT_W-1:0]          evt_duration,
  output logic [TAINT_W-1:0]        evt_peak,
  output logic [NUM_PHASES-1:0]     phase_active,
  output logic                      err_dup_start,
  output logic                      err_orphan_end,
  output logic [15:0]               drop_cnt
);

  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OCC_W  = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic [PH_W-1:0]    phase;
    logic               isEnd;
    logic [LANE_W-1:0]  lane;
    logic [CNT_W-1:0]   stamp;
    logic [CNT_W-1:0]   duration;
    logic [TAINT_W-1:0] peak;
  } evtRec_t;

  logic [CNT_W-1:0]      cycleCnt_q, cycleCnt_d;
  logic [NUM_PHASES-1:0] active_q, active_d;
  logic [CNT_W-1:0]      startTime_q [NUM_PHASES];
  logic [CNT_W-1:0]      startTime_d [NUM_PHASES];
  logic [TAINT_W-1:0]    peak_q [NUM_PHASES];
  logic [TAINT_W-1:0]    peak_d [NUM_PHASES];
  logic                  dupErr_q, dupErr_d;
  logic                  orphanErr_q, orphanErr_d;
  logic [15:0]           dropCnt_q, dropCnt_d;

  evtRec_t               fifoMem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      rdPtr_q, rdPtr_d;
  logic [PTR_W-1:0]      wrPtr_q, wrPtr_d;
  logic [OCC_W-1:0]      count_q, count_d;

  evtRec_t               laneRec [COMMIT_WIDTH];
  logic [COMMIT_WIDTH-1:0] laneFire;
  logic [COMMIT_WIDTH-1:0] laneAccept;
  logic [PTR_W-1:0]      laneSlot [COMMIT_WIDTH];
  logic                  popEn;
  int                    phIdx;
  int                    freeSlots;
  int                    pushed;
  int                    dropped;
  int                    dropSum;
  evtRec_t               headRec;

  // Walk the lanes in order so each marker sees phase state left by lower
  // lanes, build its record, then fold this cycle's taint into every phase
  // that is still active afterwards.
  always_comb begin
    active_d    = active_q;
    startTime_d = startTime_q;
    peak_d      = peak_q;
    dupErr_d    = dupErr_q;
    orphanErr_d = orphanErr_q;
    laneFire    = '0;
    phIdx       = 0;
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      laneRec[i] = '0;
      if (commit_valid[i] && (commit_inst[32*i +: 20] == 20'h02013) &&
          (int'(commit_inst[32*i+20 +: 12]) < 2*NUM_PHASES)) begin
        phIdx               = int'(commit_inst[32*i+21 +: 11]);
        laneFire[i]         = 1'b1;
        laneRec[i].phase    = PH_W'(phIdx);
        laneRec[i].isEnd    = commit_inst[32*i+20];
        laneRec[i].lane     = LANE_W'(i);
        laneRec[i].stamp    = cycleCnt_q;
        if (!laneRec[i].isEnd) begin
          if (active_d[phIdx]) begin
            dupErr_d = 1'b1;
          end
          active_d[phIdx]     = 1'b1;
          startTime_d[phIdx]  = cycleCnt_q;
          peak_d[phIdx]       = taint_sum;
          laneRec[i].duration = '0;
          laneRec[i].peak     = taint_sum;
        end else if (active_d[phIdx]) begin
          active_d[phIdx]     = 1'b0;
          laneRec[i].duration = cycleCnt_q - startTime_d[phIdx];
          laneRec[i].peak     = (taint_sum > peak_d[phIdx]) ? taint_sum : peak_d[phIdx];
        end else begin
          orphanErr_d         = 1'b1;
          laneRec[i].duration = '0;
          laneRec[i].peak     = taint_sum;
        end
      end
    end
    for (int p = 0; p < NUM_PHASES; p++) begin
      if (active_d[p] && (taint_sum > peak_d[p])) begin
        peak_d[p] = taint_sum;
      end
    end
  end

  // Hand out FIFO slots to firing lanes in lane order; space freed by this
  // cycle's pop is usable, anything beyond the free space is counted as lost.
  always_comb begin
    popEn      = (count_q != '0) && evt_ready;
    freeSlots  = FIFO_DEPTH - int'(count_q) + (popEn ? 1 : 0);
    pushed     = 0;
    dropped    = 0;
    laneAccept = '0;
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      laneSlot[i] = '0;
      if (laneFire[i]) begin
        if (pushed < freeSlots) begin
          laneAccept[i] = 1'b1;
          laneSlot[i]   = PTR_W'((int'(wrPtr_q) + pushed) % FIFO_DEPTH);
          pushed        = pushed + 1;
        end else begin
          dropped = dropped + 1;
        end
      end
    end
    count_d    = OCC_W'(int'(count_q) - (popEn ? 1 : 0) + pushed);
    wrPtr_d    = PTR_W'((int'(wrPtr_q) + pushed) % FIFO_DEPTH);
    rdPtr_d    = popEn ? PTR_W'((int'(rdPtr_q) + 1) % FIFO_DEPTH) : rdPtr_q;
    dropSum    = int'(dropCnt_q) + dropped;
    dropCnt_d  = (dropSum > 65535) ? 16'hFFFF : 16'(dropSum);
    cycleCnt_d = cycleCnt_q + CNT_W'(1);
  end

  // Control and bookkeeping state; reset drops queued records silently.
  always_ff @(posedge clock) begin
    if (reset) begin
      cycleCnt_q  <= '0;
      active_q    <= '0;
      dupErr_q    <= 1'b0;
      orphanErr_q <= 1'b0;
      dropCnt_q   <= '0;
      rdPtr_q     <= '0;
      wrPtr_q     <= '0;
      count_q     <= '0;
      for (int p = 0; p < NUM_PHASES; p++) begin
        startTime_q[p] <= '0;
        peak_q[p]      <= '0;
      end
    end else begin
      cycleCnt_q  <= cycleCnt_d;
      active_q    <= active_d;
      startTime_q <= startTime_d;
      peak_q      <= peak_d;
      dupErr_q    <= dupErr_d;
      orphanErr_q <= orphanErr_d;
      dropCnt_q   <= dropCnt_d;
      rdPtr_q     <= rdPtr_d;
      wrPtr_q     <= wrPtr_d;
      count_q     <= count_d;
    end
  end

  // Record storage; contents are only meaningful between the pointers, so
  // it needs no reset.
  always_ff @(posedge clock) begin
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      if (laneAccept[i]) begin
        fifoMem_q[laneSlot[i]] <= laneRec[i];
      end
    end
  end

  assign evt_valid      = (count_q != '0);
  assign headRec        = evt_valid ? fifoMem_q[rdPtr_q] : '0;
  assign evt_phase      = headRec.phase;
  assign evt_is_end     = headRec.isEnd;
  assign evt_lane       = headRec.lane;
  assign evt_time       = headRec.stamp;
  assign evt_duration   = headRec.duration;
  assign evt_peak       = headRec.peak;
  assign phase_active   = active_q;
  assign err_dup_start  = dupErr_q;
  assign err_orphan_end = orphanErr_q;
  assign drop_cnt       = dropCnt_q;

endmodule

// File: tb/tb_rob_phase_tracker.sv
// tb_rob_phase_tracker
// Directed scenarios followed by a randomized run, all checked against a
// queue-based reference model of the phase tracker.
module tb_rob_phase_tracker;

  localparam int CW    = 2;
  localparam int NP    = 7;
  localparam int DEPTH = 8;

  typedef struct {
    int          phase;
    bit          isEnd;
    int          lane;
    logic [31:0] stamp;
    logic [31:0] dur;
    logic [31:0] peak;
  } rec_t;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  commit_valid;
  logic [63:0] commit_inst;
  logic [31:0] taint_sum;
  logic        evt_ready;
  logic        evt_valid;
  logic [2:0]  evt_phase;
  logic        evt_is_end;
  logic [0:0]  evt_lane;
  logic [31:0] evt_time;
  logic [31:0] evt_duration;
  logic [31:0] evt_peak;
  logic [6:0]  phase_active;
  logic        err_dup_start;
  logic        err_orphan_end;
  logic [15:0] drop_cnt;

  int total = 0;
  int bad   = 0;

  rec_t        mQ[$];
  bit   [6:0]  mActive;
  bit   [31:0] mStart [NP];
  bit   [31:0] mPeak  [NP];
  bit   [31:0] mCycle;
  bit          mDup;
  bit          mOrph;
  int          mDrop;

  rob_phase_tracker #(
    .COMMIT_WIDTH(CW), .NUM_PHASES(NP), .CNT_W(32), .TAINT_W(32), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clock(clock), .reset(reset),
    .commit_valid(commit_valid), .commit_inst(commit_inst), .taint_sum(taint_sum),
    .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_phase(evt_phase), .evt_is_end(evt_is_end), .evt_lane(evt_lane),
    .evt_time(evt_time), .evt_duration(evt_duration), .evt_peak(evt_peak),
    .phase_active(phase_active), .err_dup_start(err_dup_start),
    .err_orphan_end(err_orphan_end), .drop_cnt(drop_cnt)
  );

  // Free-running 100 MHz clock.
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // A marker is slti (opcode 0x13, funct3 2) writing x0 from x0 with a code
  // naming one of the configured phases.
  function automatic bit isMarker(input logic [31:0] inst);
    return (inst[6:0] == 7'b0010011) && (inst[11:7] == 5'd0) &&
           (inst[14:12] == 3'b010) && (inst[19:15] == 5'd0) &&
           (int'(inst[31:20]) < 2*NP);
  endfunction

  task automatic checkOutput();
    check("evt_valid", evt_valid, (mQ.size() != 0));
    if (mQ.size() != 0) begin
      check("evt_phase", evt_phase, mQ[0].phase);
      check("evt_is_end", evt_is_end, mQ[0].isEnd);
      check("evt_lane", evt_lane, mQ[0].lane);
      check("evt_time", evt_time, mQ[0].stamp);
      check("evt_duration", evt_duration, mQ[0].dur);
      check("evt_peak", evt_peak, mQ[0].peak);
    end
    check("phase_active", phase_active, mActive);
    check("err_dup_start", err_dup_start, mDup);
    check("err_orphan_end", err_orphan_end, mOrph);
    check("drop_cnt", drop_cnt, mDrop);
  endtask

  // Advance the model by one cycle with the current inputs, clock the DUT,
  // then compare.
  task automatic applyStimulus();
    rec_t newRecs[$];
    int   free;
    bit   pop;
    int   drops;
    if (reset) begin
      mQ.delete();
      mActive = '0;
      mDup    = 1'b0;
      mOrph   = 1'b0;
      mDrop   = 0;
      mCycle  = '0;
      for (int p = 0; p < NP; p++) begin
        mStart[p] = '0;
        mPeak[p]  = '0;
      end
    end else begin
      pop   = (mQ.size() != 0) && evt_ready;
      free  = DEPTH - (mQ.size() - int'(pop));
      drops = 0;
      for (int i = 0; i < CW; i++) begin
        logic [31:0] inst;
        inst = commit_inst[32*i +: 32];
        if (commit_valid[i] && isMarker(inst)) begin
          int   code;
          int   p;
          rec_t r;
          code    = int'(inst[31:20]);
          p       = code / 2;
          r.phase = p;
          r.isEnd = (code % 2) == 1;
          r.lane  = i;
          r.stamp = mCycle;
          if (!r.isEnd) begin
            if (mActive[p]) mDup = 1'b1;
            mActive[p] = 1'b1;
            mStart[p]  = mCycle;
            mPeak[p]   = taint_sum;
            r.dur      = 0;
            r.peak     = taint_sum;
          end else if (mActive[p]) begin
            mActive[p] = 1'b0;
            r.dur      = mCycle - mStart[p];
            r.peak     = (taint_sum > mPeak[p]) ? taint_sum : mPeak[p];
          end else begin
            mOrph  = 1'b1;
            r.dur  = 0;
            r.peak = taint_sum;
          end
          newRecs.push_back(r);
        end
      end
      if (pop) void'(mQ.pop_front());
      foreach (newRecs[k]) begin
        if (k < free) mQ.push_back(newRecs[k]);
        else drops++;
      end
      mDrop = (mDrop + drops > 65535) ? 65535 : mDrop + drops;
      for (int p = 0; p < NP; p++) begin
        if (mActive[p] && taint_sum > mPeak[p]) mPeak[p] = taint_sum;
      end
      mCycle = mCycle + 1;
    end
    @(posedge clock);
    #1;
    checkOutput();
  endtask

  task automatic setLanes(input logic [1:0] v, input logic [31:0] i0, input logic [31:0] i1);
    commit_valid = v;
    commit_inst  = {i1, i0};
  endtask

  task automatic idle(input int n);
    setLanes(2'b00, 32'h0, 32'h0);
    for (int k = 0; k < n; k++) applyStimulus();
  endtask

  task automatic doReset();
    reset = 1'b1;
    setLanes(2'b00, 32'h0, 32'h0);
    applyStimulus();
    applyStimulus();
    reset = 1'b0;
  endtask

  function automatic logic [31:0] randInst();
    logic [11:0] code;
    case ($urandom_range(0, 9))
      7: begin code = 12'($urandom_range(14, 4095)); return {code, 20'h02013}; end
      8: begin code = 12'($urandom_range(0, 13));    return {code, 20'h02093}; end
      9: return $urandom;
      default: begin code = 12'($urandom_range(0, 13)); return {code, 20'h02013}; end
    endcase
  endfunction

  // Directed scenarios, then randomized traffic, then the summary.
  initial begin
    reset = 1'b1;
    evt_ready = 1'b1;
    taint_sum = 32'd0;
    setLanes(2'b00, 32'h0, 32'h0);
    doReset();
    check("rst_evt_valid", evt_valid, 1'b0);
    check("rst_evt_time", evt_time, 32'd0);
    check("rst_evt_peak", evt_peak, 32'd0);
    check("rst_phase_active", phase_active, 7'd0);
    check("rst_drop_cnt", drop_cnt, 16'd0);

    // Phase 1 start at cycle 10, taint spike at 18, end at 25.
    taint_sum = 32'd5;
    idle(10);
    setLanes(2'b01, 32'h00202013, 32'h0);
    applyStimulus();
    check("p1_start_phase", evt_phase, 3'd1);
    check("p1_start_is_end", evt_is_end, 1'b0);
    check("p1_start_time", evt_time, 32'd10);
    check("p1_start_peak", evt_peak, 32'd5);
    check("p1_active_set", phase_active[1], 1'b1);
    idle(7);
    taint_sum = 32'd9;
    applyStimulus();
    taint_sum = 32'd5;
    idle(6);
    check("p1_active_c25", phase_active[1], 1'b1);
    setLanes(2'b01, 32'h00302013, 32'h0);
    applyStimulus();
    check("p1_end_is_end", evt_is_end, 1'b1);
    check("p1_end_time", evt_time, 32'd25);
    check("p1_end_duration", evt_duration, 32'd15);
    check("p1_end_peak", evt_peak, 32'd9);
    check("p1_active_clr", phase_active[1], 1'b0);

    // Start and end of phase 0 in one cycle on lanes 0/1.
    setLanes(2'b11, 32'h00002013, 32'h00102013);
    applyStimulus();
    check("same_cyc_first_start", evt_is_end, 1'b0);
    check("same_cyc_first_lane", evt_lane, 1'b0);
    check("same_cyc_active0", phase_active[0], 1'b0);
    idle(1);
    check("same_cyc_second_end", evt_is_end, 1'b1);
    check("same_cyc_second_lane", evt_lane, 1'b1);
    check("same_cyc_duration", evt_duration, 32'd0);

    // Orphan end on phase 2, then a duplicate start on phase 0.
    setLanes(2'b01, 32'h00502013, 32'h0);
    applyStimulus();
    check("orphan_flag", err_orphan_end, 1'b1);
    check("orphan_phase", evt_phase, 3'd2);
    check("orphan_duration", evt_duration, 32'd0);
    setLanes(2'b01, 32'h00002013, 32'h0);
    applyStimulus();
    idle(3);
    setLanes(2'b01, 32'h00002013, 32'h0);
    applyStimulus();
    check("dup_flag", err_dup_start, 1'b1);
    idle(4);
    setLanes(2'b01, 32'h00102013, 32'h0);
    applyStimulus();
    check("dup_restart_duration", evt_duration, 32'd5);

    // Ten markers against a stalled consumer overflow the 8-entry FIFO.
    doReset();
    evt_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      setLanes(2'b01, (k % 2 == 0) ? 32'h00802013 : 32'h00902013, 32'h0);
      applyStimulus();
    end
    check("full_drop_cnt", drop_cnt, 16'd2);
    check("full_head_time", evt_time, 32'd0);
    check("full_head_phase", evt_phase, 3'd4);
    evt_ready = 1'b1;
    idle(8);
    check("drained_valid", evt_valid, 1'b0);

    // Out-of-range code and non-x0 destination are not markers.
    setLanes(2'b11, 32'h01002013, 32'h00002093);
    applyStimulus();
    check("nonmarker_valid", evt_valid, 1'b0);
    check("nonmarker_active", phase_active, 7'd0);

    // Reset pulse with records queued and phase 3 active.
    evt_ready = 1'b0;
    setLanes(2'b01, 32'h00602013, 32'h0);
    applyStimulus();
    setLanes(2'b01, 32'h00A02013, 32'h0);
    applyStimulus();
    setLanes(2'b01, 32'h00B02013, 32'h0);
    applyStimulus();
    reset = 1'b1;
    setLanes(2'b00, 32'h0, 32'h0);
    applyStimulus();
    reset = 1'b0;
    check("pulse_valid", evt_valid, 1'b0);
    check("pulse_active", phase_active, 7'd0);
    check("pulse_drop_cnt", drop_cnt, 16'd0);
    evt_ready = 1'b1;
    setLanes(2'b01, 32'h00C02013, 32'h0);
    applyStimulus();
    check("pulse_cycle_restart", evt_time, 32'd0);

    // Randomized traffic with a flaky consumer.
    doReset();
    for (int c = 0; c < 600; c++) begin
      setLanes(2'($urandom_range(0, 3)), randInst(), randInst());
      taint_sum = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 20));
      evt_ready = (c % 100 < 30) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 3) != 0);
      applyStimulus();
    end
    evt_ready = 1'b1;
    idle(DEPTH + 2);
    check("final_drained", evt_valid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
